// File: rtl/display_pkg.sv
// Shared constants, letter codes and state encoding for the display scanner.
// Also holds the per-nibble add-3 correction used by the BCD converter.
package display_pkg;

  localparam int VALUE_W           = 14;
  localparam int NUM_DIGITS        = 4;
  localparam int MAX_DISPLAY_VALUE = 9999;

  localparam logic [3:0] CODE_E = 4'b1100;
  localparam logic [3:0] CODE_R = 4'b1110;
  localparam logic [3:0] CODE_O = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/display_scanner_if.sv
// Load/error request side and scanned digit outputs of the display scanner.
interface display_scanner_if #(
  parameter int VALUE_WIDTH = 14
);
  logic [VALUE_WIDTH-1:0] value;
  logic                   load;
  logic                   error;
  logic                   busy;
  logic [3:0]             data;
  logic [3:0]             digit_sel;

  modport master (output value, load, error, input busy, data, digit_sel);
  modport slave  (input value, load, error, output busy, data, digit_sel);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary to 4-digit BCD converter, one bit per cycle.
// done is high during the final iteration; bcd is valid the cycle after.
module bin_to_bcd_seq
  import display_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             done,
  output logic [15:0]      bcd
);

  logic             running;
  logic [3:0]       iter;
  logic [BIN_W-1:0] bin_sr;
  logic [15:0]      bcd_adj;

  assign done = running && (iter == 4'(BIN_W - 1));

  always_comb begin
    bcd_adj = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      bcd_adj[4*k +: 4] = add3(bcd[4*k +: 4]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      running <= 1'b0;
      iter    <= 4'd0;
    end else if (start) begin
      running <= 1'b1;
      iter    <= 4'd0;
    end else if (running) begin
      if (done) running <= 1'b0;
      iter <= iter + 4'd1;
    end
  end

  // The ten-thousands carry falls off the top; such values are flagged by the caller.
  always_ff @(posedge clock) begin
    if (start) begin
      bin_sr <= bin_in;
      bcd    <= '0;
    end else if (running) begin
      bcd    <= {bcd_adj[14:0], bin_sr[BIN_W-1]};
      bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/display_scanner.sv
// Four-digit multiplexed 7-segment scanner: converts a binary value to BCD,
// commits it (or flags out-of-range), and scans digits or "Erro" continuously.
module display_scanner
  import display_pkg::*;
#(
  parameter int SCAN_DIV    = 1000,
  parameter int VALUE_WIDTH = 14
) (
  input  logic              clock,
  input  logic              reset,
  display_scanner_if.slave  disp
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t        state, state_nx;
  logic          start;
  logic          conv_done;
  logic [15:0]   conv_bcd;
  logic          over;
  logic          range_err;
  logic [15:0]   digits;
  logic [PW-1:0] presc;
  logic [1:0]    idx, idx_nx;
  logic          wrap;
  logic [3:0]    data_r, sel_r;

  function automatic logic [3:0] slot_code(input logic [1:0] i, input logic show_err,
                                           input logic [15:0] d);
    if (show_err) begin
      case (i)
        2'd3:    return CODE_E;
        2'd0:    return CODE_O;
        default: return CODE_R;
      endcase
    end
    return d[{i, 2'b00} +: 4];
  endfunction

  bin_to_bcd_seq #(.BIN_W(VALUE_WIDTH)) u_conv (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .bin_in (disp.value),
    .done   (conv_done),
    .bcd    (conv_bcd)
  );

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    case (state)
      ST_IDLE: if (disp.load) begin
        start    = 1'b1;
        state_nx = ST_CONVERT;
      end
      ST_CONVERT: if (conv_done) state_nx = ST_COMMIT;
      ST_COMMIT:  state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  assign disp.busy = (state != ST_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      over      <= 1'b0;
      range_err <= 1'b0;
      digits    <= '0;
    end else begin
      state <= state_nx;
      if (start) over <= (disp.value > VALUE_WIDTH'(MAX_DISPLAY_VALUE));
      if (state == ST_COMMIT) begin
        range_err <= over;
        if (!over) digits <= conv_bcd;
      end
    end
  end

  // Scan stage: index, enable and code all register on the same edge.
  assign wrap   = (presc == PW'(SCAN_DIV - 1));
  assign idx_nx = wrap ? idx + 2'd1 : idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc  <= '0;
      idx    <= 2'd0;
      sel_r  <= 4'b0001;
      data_r <= 4'b0000;
    end else begin
      presc  <= wrap ? '0 : presc + PW'(1);
      idx    <= idx_nx;
      sel_r  <= 4'b0001 << idx_nx;
      data_r <= slot_code(idx_nx, disp.error || range_err, digits);
    end
  end

  assign disp.data      = data_r;
  assign disp.digit_sel = sel_r;

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner: a decimal reference model predicts the
// scanned codes, enables and busy flag; a negedge monitor compares every cycle.
module tb_display_scanner;
  import display_pkg::*;

  localparam int SD = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  display_scanner_if #(.VALUE_WIDTH(14)) disp();

  display_scanner #(.SCAN_DIV(SD), .VALUE_WIDTH(14)) dut (
    .clock (clock),
    .reset (reset),
    .disp  (disp)
  );

  always #5 clock = ~clock;

  typedef struct {
    int due;
    int val;
  } commit_t;

  commit_t    sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         t, free_at, m_idx;
  logic       m_rng;
  logic [3:0] m_dig[4];
  logic [3:0] exp_data, exp_sel;
  logic       exp_busy;
  commit_t    c;

  function automatic logic [3:0] letter(input int i);
    case (i)
      3:       return 4'b1100;
      0:       return 4'b1111;
      default: return 4'b1110;
    endcase
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      if (miscompares <= 50)
        $display("FAIL %s at t=%0d: actual=%b expected=%b", name, t, act, expv);
    end
  endtask

  // Reference model: edge count since reset gives the slot; decimal digits via / and %.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      t = 0; free_at = 0; m_rng = 1'b0;
      for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
      sb.delete();
      exp_data = 4'd0; exp_sel = 4'b0001; exp_busy = 1'b0;
    end else begin
      t++;
      m_idx    = (t / SD) % 4;
      exp_sel  = 4'(1 << m_idx);
      exp_data = (disp.error || m_rng) ? letter(m_idx) : m_dig[m_idx];
      if (sb.size() != 0 && sb[0].due == t) begin
        c = sb.pop_front();
        if (c.val > 9999) m_rng = 1'b1;
        else begin
          m_rng = 1'b0;
          m_dig[0] = 4'(c.val % 10);
          m_dig[1] = 4'((c.val / 10) % 10);
          m_dig[2] = 4'((c.val / 100) % 10);
          m_dig[3] = 4'((c.val / 1000) % 10);
        end
      end
      if (disp.load && t >= free_at) begin
        sb.push_back('{due: t + 15, val: int'(disp.value)});
        free_at = t + 16;
      end
      exp_busy = (t < free_at - 1);
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      check("data", disp.data, exp_data);
      check("digit_sel", disp.digit_sel, exp_sel);
      check("busy", {3'b000, disp.busy}, {3'b000, exp_busy});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_load(input int v);
    @(negedge clock);
    disp.value = 14'(v);
    disp.load  = 1'b1;
    @(negedge clock);
    disp.load  = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_data"}, disp.data, 4'b0000);
    check({tag, "_sel"}, disp.digit_sel, 4'b0001);
    check({tag, "_busy"}, {3'b000, disp.busy}, 4'b0000);
  endtask

  initial begin
    int sel, gap;
    disp.value = '0;
    disp.load  = 1'b0;
    disp.error = 1'b0;
    repeat (3) @(negedge clock);
    #1 check_reset_state("reset");
    #1 reset = 1'b0;

    idle(20);
    do_load(1234);  idle(40);
    do_load(42);    idle(40);
    do_load(10000); idle(40);
    do_load(7);     idle(40);

    do_load(9999);  idle(20);
    disp.error = 1'b1; idle(3 * 4 * SD);
    disp.error = 1'b0; idle(30);

    do_load(321); idle(4);
    do_load(55);  idle(40);

    disp.error = 1'b1;
    do_load(500); idle(20);
    disp.error = 1'b0; idle(20);

    do_load(8888); idle(6);
    @(negedge clock);
    #2 reset = 1'b1;
    #1 check_reset_state("midreset");
    @(negedge clock);
    #2 reset = 1'b0;
    idle(40);

    do_load(0);     idle(20);
    do_load(9999);  idle(20);
    do_load(10000); idle(20);
    do_load(16383); idle(20);

    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 5));
      case (sel)
        0:       do_load(0);
        1:       do_load(9999);
        2:       do_load(10000);
        3:       do_load(16383);
        default: do_load(int'($urandom_range(0, 16383)));
      endcase
      if ($urandom_range(0, 3) == 0) begin
        disp.error = 1'b1;
        idle(int'($urandom_range(1, 10)));
        disp.error = 1'b0;
      end
      gap = int'($urandom_range(0, 30));
      idle(gap);
    end
    idle(4 * SD);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
